// File: rtl/ntt_basemul.sv
// ntt_basemul -- pointwise multiplier for NTT-domain polynomials.
//
// Each input beat is one degree-1 coefficient pair. The block computes
//   c = (a0 + a1*X)(b0 + b1*X) mod (X^2 - g),  g = odd(pair) ? -zeta : +zeta
// giving c0 = a0*b0 + a1*b1*g and c1 = a0*b1 + a1*b0, both mod Q.
// Five-stage pipeline, one pair per clock, fixed latency, no backpressure.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   clr             synchronous frame restart (pair counter back to 0)
//   in_en           input beat valid
//   in_a, in_b      {x0,x1} canonical coefficient pairs
//   zeta_addr       zeta ROM address for the beat currently on in_*
//   zeta_data       zeta ROM data, one cycle after zeta_addr
//   out_en          output beat valid (in_en delayed by LATENCY)
//   out             {c0,c1} canonical product pair; holds while out_en=0
//   out_last        marks the last pair of a frame
module ntt_basemul #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int N          = 256,
  parameter int ZA_W       = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_en,
  input  logic [2*DATA_WIDTH-1:0] in_a,
  input  logic [2*DATA_WIDTH-1:0] in_b,
  output logic [ZA_W-1:0]         zeta_addr,
  input  logic [DATA_WIDTH-1:0]   zeta_data,
  output logic                    out_en,
  output logic [2*DATA_WIDTH-1:0] out,
  output logic                    out_last
);

  localparam int LATENCY = 5;
  localparam int DW      = DATA_WIDTH;
  localparam int PW      = $clog2(N/2);
  localparam int BK      = 2*DW;

  localparam logic [PW-1:0] LASTP = PW'(N/2 - 1);
  localparam logic [DW-1:0] QD    = DW'(Q);
  localparam logic [DW:0]   QE    = (DW+1)'(Q);
  localparam logic [BK-1:0] QK    = BK'(Q);
  // Barrett constant floor(2^BK / Q). Since every product is < 2^BK the
  // quotient estimate is off by at most one, so one conditional subtract
  // finishes the reduction.
  localparam logic [BK-1:0] BM    = BK'((64'd1 << BK) / Q);

  function automatic logic [BK-1:0] mulw(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return BK'(x) * BK'(y);
  endfunction

  function automatic logic [DW-1:0] red(input logic [BK-1:0] x);
    logic [2*BK-1:0] prod;
    logic [BK-1:0]   qe;
    logic [BK-1:0]   r;
    prod = {{BK{1'b0}}, x} * {{BK{1'b0}}, BM};
    qe   = prod[2*BK-1:BK];
    r    = x - qe * QK;
    if (r >= QK) r = r - QK;
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] addq(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QE) s = s - QE;
    return s[DW-1:0];
  endfunction

  logic [PW-1:0]            pidx_q, pidx_d, cur_pidx;
  logic                     is_last;
  logic [LATENCY:1]         vld_pipe_q, vld_pipe_d;
  logic [LATENCY:1]         last_pipe_q, last_pipe_d;
  // S1 operands: [0]=a0 [1]=a1 [2]=b0 [3]=b1
  logic [3:0][DW-1:0]       op_s1_q, op_s1_d;
  logic                     odd_s1_q, odd_s1_d;
  // S2 products: [0]=a0b0 [1]=a1b1 [2]=a0b1 [3]=a1b0
  logic [3:0][BK-1:0]       prod_s2_q, prod_s2_d;
  logic                     odd_s2_q, odd_s2_d;
  logic [DW-1:0]            z_s2_q, z_s2_d;
  logic [3:0][DW-1:0]       red_s3_q, red_s3_d;
  logic [DW-1:0]            g_s3_q, g_s3_d;
  // S4 linear terms: [0]=a0b0 [1]=a0b1 [2]=a1b0
  logic [2:0][DW-1:0]       lin_s4_q, lin_s4_d;
  logic [BK-1:0]            m_s4_q, m_s4_d;
  logic [2*DW-1:0]          out_q, out_d;

  // clr together with in_en makes the present beat pair 0.
  assign cur_pidx  = clr ? '0 : pidx_q;
  assign is_last   = (cur_pidx == LASTP);
  assign zeta_addr = ZA_W'(cur_pidx >> 1);

  always_comb begin
    pidx_d      = pidx_q;
    vld_pipe_d  = {vld_pipe_q[LATENCY-1:1], in_en};
    last_pipe_d = {last_pipe_q[LATENCY-1:1], in_en & is_last};
    op_s1_d     = op_s1_q;
    odd_s1_d    = odd_s1_q;
    prod_s2_d   = prod_s2_q;
    odd_s2_d    = odd_s2_q;
    z_s2_d      = z_s2_q;
    red_s3_d    = red_s3_q;
    g_s3_d      = g_s3_q;
    lin_s4_d    = lin_s4_q;
    m_s4_d      = m_s4_q;
    out_d       = out_q;

    if (in_en)    pidx_d = (cur_pidx == LASTP) ? '0 : cur_pidx + PW'(1);
    else if (clr) pidx_d = '0;

    // S1: capture operands and pair parity
    if (in_en) begin
      op_s1_d  = {in_b[DW-1:0], in_b[2*DW-1:DW], in_a[DW-1:0], in_a[2*DW-1:DW]};
      odd_s1_d = cur_pidx[0];
    end
    // S2: zeta arrives from the synchronous ROM this cycle
    if (vld_pipe_q[1]) begin
      prod_s2_d[0] = mulw(op_s1_q[0], op_s1_q[2]);
      prod_s2_d[1] = mulw(op_s1_q[1], op_s1_q[3]);
      prod_s2_d[2] = mulw(op_s1_q[0], op_s1_q[3]);
      prod_s2_d[3] = mulw(op_s1_q[1], op_s1_q[2]);
      odd_s2_d     = odd_s1_q;
      z_s2_d       = zeta_data;
    end
    // S3: reduce products; odd pairs use -zeta, kept canonical for zeta=0
    if (vld_pipe_q[2]) begin
      for (int i = 0; i < 4; i++) red_s3_d[i] = red(prod_s2_q[i]);
      g_s3_d = (odd_s2_q && z_s2_q != '0) ? QD - z_s2_q : z_s2_q;
    end
    // S4: twist a1b1 by g
    if (vld_pipe_q[3]) begin
      lin_s4_d = {red_s3_q[3], red_s3_q[2], red_s3_q[0]};
      m_s4_d   = mulw(red_s3_q[1], g_s3_q);
    end
    // S5: final reduce and modular adds
    if (vld_pipe_q[4]) begin
      out_d = {addq(lin_s4_q[0], red(m_s4_q)), addq(lin_s4_q[1], lin_s4_q[2])};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pidx_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      op_s1_q     <= '0;
      odd_s1_q    <= 1'b0;
      prod_s2_q   <= '0;
      odd_s2_q    <= 1'b0;
      z_s2_q      <= '0;
      red_s3_q    <= '0;
      g_s3_q      <= '0;
      lin_s4_q    <= '0;
      m_s4_q      <= '0;
      out_q       <= '0;
    end else begin
      pidx_q      <= pidx_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      op_s1_q     <= op_s1_d;
      odd_s1_q    <= odd_s1_d;
      prod_s2_q   <= prod_s2_d;
      odd_s2_q    <= odd_s2_d;
      z_s2_q      <= z_s2_d;
      red_s3_q    <= red_s3_d;
      g_s3_q      <= g_s3_d;
      lin_s4_q    <= lin_s4_d;
      m_s4_q      <= m_s4_d;
      out_q       <= out_d;
    end
  end

  assign out_en   = vld_pipe_q[LATENCY];
  assign out_last = last_pipe_q[LATENCY];
  assign out      = out_q;

endmodule

// File: tb/tb_ntt_basemul.sv
// Directed and random bench for ntt_basemul with a synchronous zeta ROM model.
module tb_ntt_basemul;
  localparam int DW = 12, Q = 3329, N = 256, ZA_W = 6;

  logic            clk = 1'b0, rst = 1'b0, clr = 1'b0, in_en = 1'b0;
  logic [2*DW-1:0] in_a = '0, in_b = '0;
  logic [ZA_W-1:0] zeta_addr;
  logic [DW-1:0]   zeta_data;
  logic            out_en, out_last;
  logic [2*DW-1:0] out;

  always #5 clk = ~clk;

  ntt_basemul #(.DATA_WIDTH(DW), .Q(Q), .N(N), .ZA_W(ZA_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_en(in_en), .in_a(in_a), .in_b(in_b),
    .zeta_addr(zeta_addr), .zeta_data(zeta_data),
    .out_en(out_en), .out(out), .out_last(out_last)
  );

  int zrom [64];
  always @(posedge clk) zeta_data <= DW'(zrom[zeta_addr]);

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int c0; int c1; bit last; } exp_t;
  exp_t exq[$];
  int   mp = 0;  // model pair index

  function automatic int mod_c0(int a0, int a1, int b0, int b1, int z, bit odd);
    longint g;
    g = odd ? (Q - z) % Q : z;
    return int'((longint'(a0) * b0 + ((longint'(a1) * b1) % Q) * g) % Q);
  endfunction

  function automatic int mod_c1(int a0, int a1, int b0, int b1);
    return int'((longint'(a0) * b1 + longint'(a1) * b0) % Q);
  endfunction

  // expected out_en: in_en as sampled, delayed five cycles
  logic [4:0] hist;
  always @(posedge clk or negedge rst)
    if (!rst) hist <= '0;
    else      hist <= {hist[3:0], in_en};

  logic [2*DW-1:0] last_out = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) last_out = '0;
    chk("out_en", out_en, hist[4]);
    if (out_en) begin
      if (exq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = exq.pop_front();
        chk("c0", out[2*DW-1:DW], e.c0);
        chk("c1", out[DW-1:0], e.c1);
        chk("out_last", out_last, e.last);
      end
      last_out = out;
    end else begin
      chk("out_hold", out, last_out);
      chk("out_last_idle", out_last, 0);
    end
  end

  // one beat, entered at posedge+1 and left at the next posedge+1
  task automatic beat(input int a0, a1, b0, b1, input bit c = 0,
                      input bit hand = 0, input int h0 = 0, input int h1 = 0);
    int p; exp_t e;
    in_en = 1'b1; clr = c;
    in_a = {DW'(a0), DW'(a1)};
    in_b = {DW'(b0), DW'(b1)};
    p = c ? 0 : mp;
    #1;
    chk("zeta_addr", zeta_addr, p >> 1);
    if (rst) begin
      e.c0   = hand ? h0 : mod_c0(a0, a1, b0, b1, zrom[p >> 1], p[0]);
      e.c1   = hand ? h1 : mod_c1(a0, a1, b0, b1);
      e.last = (p == N/2 - 1);
      exq.push_back(e);
      mp = (p == N/2 - 1) ? 0 : p + 1;
    end
    @(posedge clk); #1;
    in_en = 1'b0; clr = 1'b0;
  endtask

  task automatic rbeat(input bit c = 0);
    beat($urandom_range(0, Q-1), $urandom_range(0, Q-1),
         $urandom_range(0, Q-1), $urandom_range(0, Q-1), c);
  endtask

  task automatic idle(input int n, input bit c = 0);
    in_en = 1'b0; clr = c;
    if (c) mp = 0;
    repeat (n) begin @(posedge clk); #1; end
    clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) zrom[i] = (i * 1723 + 11) % Q;
    zrom[0] = 17;
    zrom[1] = 0;

    // T1: held in reset with in_en high
    rst = 1'b0; in_en = 1'b1; in_a = 24'h123456; in_b = 24'h0abcde;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_en", out_en, 0);
    chk("rst_out", out, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_zeta_addr", zeta_addr, 0);
    in_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // T2: pair 0 and odd pair 1
    beat(1, 0, 5, 7, 0, 1, 5, 7);
    beat(0, 1, 0, 1, 0, 1, 3312, 0);
    idle(8);

    // T3: Q-1 operands at pair 0, then zeta=0 at pair 2
    beat(3328, 3328, 3328, 3328, 1, 1, 18, 2);
    rbeat();
    beat(2, 3, 4, 5, 0, 1, 8, 22);
    idle(8);

    // T4: full frame back to back, then first beat of the next frame
    idle(1, 1);
    for (int i = 0; i < N/2; i++) rbeat();
    rbeat();
    idle(8);

    // T5: random bubbles, then clr with a beat at pair 37
    while (mp != 37) begin
      rbeat();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rbeat(1);
    rbeat();
    rbeat();
    idle(2, 1);
    for (int i = 0; i < 12; i++) begin
      rbeat();
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    idle(8);

    // T6: reset pulse two beats into a four-beat burst
    rbeat();
    rbeat();
    rst = 1'b0;
    exq.delete();
    mp = 0;
    rbeat();
    rbeat();
    rst = 1'b1;
    idle(10);
    rbeat();
    rbeat();
    rbeat();
    idle(8);

    chk("queue_drained", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
